// File: rtl/minibus_timer_slave.sv
// minibus_timer_slave: 64-bit memory-mapped timer on a minibus slave port with wait-state handshake.
// Optional build macro MINIBUS_TIMER_ERR_EN reports unmapped or misaligned accesses through res_error_o.
`timescale 1ns/1ps
`default_nettype none

module minibus_timer_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic        req_ren_i,
  input  logic        req_wen_i,
  input  logic [3:0]  req_byte_en_i,
  output logic [31:0] res_data_o,
  output logic        res_ready_o,
  output logic        res_error_o,
  output logic        timer_irq_o
);

  localparam logic [3:0]  WS_INIT    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic [4:0]  addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        wen_q;
  logic        legal_q;
  logic        ready_q;
  logic [31:0] rdata_q;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        pend_q, pend_d;
  logic        irq_q;
  logic [15:0] presc_q;

  logic        w_valid;
  logic [4:0]  w_rd_addr;
  logic        w_rd_ok;
  logic [31:0] w_rd_data;
  logic        w_tick;
  logic        w_commit;
  logic        w_w1c;
  logic        w_unused;

  assign w_unused  = ^req_addr_i[31:5];
  assign w_valid   = sel_i & (req_ren_i | req_wen_i);
  // In IDLE the address comes straight from the bus so WAIT_STATES=0 can respond immediately.
  assign w_rd_addr = (state_q == S_IDLE) ? req_addr_i[4:0] : addr_q;
  assign w_rd_ok   = (w_rd_addr[1:0] == 2'b00) && (w_rd_addr[4:2] <= 3'd5);
  assign w_tick    = en_q && (presc_q == PRESC_LAST);
  assign w_commit  = (state_q == S_RESP) && wen_q && legal_q;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    w_rd_data = 32'd0;
    if (w_rd_ok) begin
      case (w_rd_addr[4:2])
        3'd0:    w_rd_data = mtime_q[31:0];
        3'd1:    w_rd_data = mtime_q[63:32];
        3'd2:    w_rd_data = cmp_q[31:0];
        3'd3:    w_rd_data = cmp_q[63:32];
        3'd4:    w_rd_data = {30'd0, irq_en_q, en_q};
        3'd5:    w_rd_data = {31'd0, pend_q};
        default: w_rd_data = 32'd0;
      endcase
    end
  end

  // Written bytes override the incremented value; the other half keeps its normal increment.
  always_comb begin
    mtime_d  = mtime_q + {63'd0, w_tick};
    cmp_d    = cmp_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    w_w1c    = 1'b0;
    if (w_commit) begin
      case (addr_q[4:2])
        3'd0: mtime_d[31:0]  = merge_bytes(mtime_d[31:0], wdata_q, be_q);
        3'd1: mtime_d[63:32] = merge_bytes(mtime_d[63:32], wdata_q, be_q);
        3'd2: cmp_d[31:0]    = merge_bytes(cmp_q[31:0], wdata_q, be_q);
        3'd3: cmp_d[63:32]   = merge_bytes(cmp_q[63:32], wdata_q, be_q);
        3'd4: begin
          if (be_q[0]) begin
            en_d     = wdata_q[0];
            irq_en_d = wdata_q[1];
          end
        end
        3'd5: w_w1c = be_q[0] & wdata_q[0];
        default: ;
      endcase
    end
    pend_d = (en_q && (mtime_q >= cmp_q)) | (pend_q & ~w_w1c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q  <= 64'd0;
      cmp_q    <= {64{1'b1}};
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
      presc_q  <= 16'd0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
      irq_q    <= pend_q & irq_en_q;
      if (en_q) presc_q <= w_tick ? 16'd0 : presc_q + 16'd1;
    end
  end

`ifdef MINIBUS_TIMER_ERR_EN
  logic error_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= 5'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      wen_q   <= 1'b0;
      legal_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
`ifdef MINIBUS_TIMER_ERR_EN
      error_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_valid) begin
            addr_q  <= req_addr_i[4:0];
            wdata_q <= req_data_i;
            be_q    <= req_byte_en_i;
            wen_q   <= req_wen_i;
            legal_q <= w_rd_ok;
            wcnt_q  <= WS_INIT;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              rdata_q <= w_rd_data;
`ifdef MINIBUS_TIMER_ERR_EN
              error_q <= ~w_rd_ok;
`endif
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wcnt_q == 4'd0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            rdata_q <= w_rd_data;
`ifdef MINIBUS_TIMER_ERR_EN
            error_q <= ~w_rd_ok;
`endif
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          rdata_q <= 32'd0;
`ifdef MINIBUS_TIMER_ERR_EN
          error_q <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res_data_o  = rdata_q;
  assign res_ready_o = ready_q;
  assign timer_irq_o = irq_q;
`ifdef MINIBUS_TIMER_ERR_EN
  assign res_error_o = error_q;
`else
  assign res_error_o = 1'b0;
`endif

endmodule

`default_nettype wire
